serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 119 +++++++++++
 tb/tb_serial_add_sub.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry FF, one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_SAT_EN to saturate the result on signed overflow.
module serial_add_sub #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned SUM_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
`ifdef SERIAL_ADD_SUB_SAT_EN
  logic             r_a_msb;
`endif

  logic             w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;

  // Full-adder cell; on the last bit r_carry is the carry into the MSB.
  always_comb begin
    w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    w_cout  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_ovf   = r_carry ^ w_cout;
    w_final = {w_sum, r_sum};
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (w_ovf) begin
      w_final = r_a_msb ? {1'b1, {SUM_W{1'b0}}} : {1'b0, {SUM_W{1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
`ifdef SERIAL_ADD_SUB_SAT_EN
      r_a_msb   <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as a + ~b + 1: the +1 enters through the carry FF.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
`ifdef SERIAL_ADD_SUB_SAT_EN
            r_a_msb <= a[WIDTH-1];
`endif
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= SUM_W'({w_sum, r_sum} >> 1);
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            result    <= w_final;
            carry_out <= w_cout;
            overflow  <= w_ovf;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=6) with an expected-result scoreboard queue.
// Honours SERIAL_ADD_SUB_SAT_EN in its reference model.
module tb_serial_add_sub;

  localparam int unsigned W = 6;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    exp_t         e;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.r  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (e.o) e.r = x[W-1] ? 6'b100000 : 6'b011111;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL reset_result got %b want 000000", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
  endtask

  // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input string nm);
    exp_t         e;
    logic [W-1:0] held;
    int           n;
    bit           moved;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    sb.push_back(model(ta, tb_v, ts));
    held = result;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got %b want 1", nm, busy); end
    n = 0; moved = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (result !== held) moved = 1'b1;
      tick();
      n++;
    end
    checks++; if (n != W) begin errors++; $display("FAIL %s done_latency got %0d want %0d", nm, n, W); end
    checks++; if (moved) begin errors++; $display("FAIL %s result_held got changed want held %b", nm, held); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", nm, busy); end
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      checks++; if (result !== e.r) begin errors++; $display("FAIL %s result got %b want %b", nm, result, e.r); end
      checks++; if (carry_out !== e.c) begin errors++; $display("FAIL %s carry got %b want %b", nm, carry_out, e.c); end
      checks++; if (overflow !== e.o) begin errors++; $display("FAIL %s ovf got %b want %b", nm, overflow, e.o); end
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_one_cycle got %b want 0", nm, done); end
  endtask

  task automatic test_arith();
    run_op(6'b000001, 6'b000001, 1'b1, "sub_equal");
    run_op(6'b010011, 6'b010101, 1'b0, "add_pos_ovf");
    run_op(6'b111111, 6'b000000, 1'b1, "sub_zero");
    run_op(6'b000000, 6'b000001, 1'b1, "sub_borrow");
    run_op(6'b100000, 6'b000001, 1'b1, "sub_neg_ovf");
    run_op(6'b111111, 6'b111111, 1'b0, "add_max");
    for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   dones;
    int   first_n;
    logic [W-1:0] got;
    do_reset(1);
    e = model(6'b000111, 6'b000010, 1'b0);
    a = 6'b000111; b = 6'b000010; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; first_n = -1; got = '0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 2) begin a = 6'b111000; b = 6'b000101; sub = 1'b1; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (done === 1'b1) begin
        if (dones == 0) begin first_n = n; got = result; end
        dones++;
      end
    end
    start = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    checks++; if (first_n != W) begin errors++; $display("FAIL ignore_latency got %0d want %0d", first_n, W); end
    checks++; if (got !== e.r) begin errors++; $display("FAIL ignore_result got %b want %b", got, e.r); end
  endtask

  task automatic test_hold_start();
    int   acc[$];
    logic pb;
    exp_t e;
    do_reset(1);
    e = model(6'b000011, 6'b000101, 1'b0);
    a = 6'b000011; b = 6'b000101; sub = 1'b0; start = 1'b1;
    pb = busy;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (busy === 1'b1 && pb !== 1'b1) acc.push_back(cyc);
      pb = busy;
    end
    start = 1'b0;
    checks++; if (acc.size() < 3) begin errors++; $display("FAIL hold_accepts got %0d want >=3", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != W + 2) begin
        errors++; $display("FAIL hold_spacing got %0d want %0d", acc[i] - acc[i-1], W + 2);
      end
    end
    checks++; if (result !== e.r) begin errors++; $display("FAIL hold_result got %b want %b", result, e.r); end
  endtask

  task automatic test_reset_mid();
    int dones;
    do_reset(1);
    a = 6'b010101; b = 6'b001010; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL midrst_result got %b want 000000", result); end
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL midrst_result_later got %b want 000000", result); end
  endtask

  initial begin
    tick();
    test_reset();
    test_arith();
    test_ignore_start();
    test_hold_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
